// File: rtl/iprf_if.sv
// iprf_if: read/write bus of the integer physical register file.
//
// Parameters:
//   NUM_RD   - number of read ports (one per RS source operand)
//   NUM_WR   - number of writeback ports; defaults to the IPRF_NUM_WRITES
//              macro, which falls back to 2 when the build does not set it
//   PRF_ID_W - width of a physical-register id (pdst / read address)
//
// Signals:
//   iprf_wr_en_ro0   [NUM_WR]   writeback port valid
//   iprf_wr_pkt_ro0  [NUM_WR]   writeback packet {pdst, data}
//   prf_rdens_rd0    [NUM_RD]   read-port enable
//   prf_rdaddrs_rd0  [NUM_RD]   read address
//   prf_rddatas_rd1  [NUM_RD]   registered read data (cycle after enable)
//
// Modports: master drives requests (RS / writeback side), slave is the file.

`ifndef IPRF_NUM_WRITES
`define IPRF_NUM_WRITES 2
`endif

interface iprf_if #(
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = `IPRF_NUM_WRITES,
    parameter int PRF_ID_W = 8
);
    typedef logic [PRF_ID_W-1:0] t_prf_id;
    typedef logic [63:0]         t_rv_reg_data;

    typedef struct packed {
        t_prf_id      pdst;
        t_rv_reg_data data;
    } t_prf_wr_pkt;

    logic [NUM_WR-1:0] iprf_wr_en_ro0;
    t_prf_wr_pkt       iprf_wr_pkt_ro0 [NUM_WR];
    logic [NUM_RD-1:0] prf_rdens_rd0;
    t_prf_id           prf_rdaddrs_rd0 [NUM_RD];
    t_rv_reg_data      prf_rddatas_rd1 [NUM_RD];

    modport master (
        output iprf_wr_en_ro0,
        output iprf_wr_pkt_ro0,
        output prf_rdens_rd0,
        output prf_rdaddrs_rd0,
        input  prf_rddatas_rd1
    );

    modport slave (
        input  iprf_wr_en_ro0,
        input  iprf_wr_pkt_ro0,
        input  prf_rdens_rd0,
        input  prf_rdaddrs_rd0,
        output prf_rddatas_rd1
    );
endinterface

// File: rtl/iprf.sv
// iprf: integer physical register file.
//
// NUM_ENTRIES x 64-bit flops with NUM_RD registered read ports and NUM_WR
// writeback ports. Entry 0 is hardwired to zero: writes to it are dropped
// and reads of it return 0. Only the low log2(NUM_ENTRIES) bits of an id
// select an entry, so ids can never address out of range
// (NUM_ENTRIES must not exceed 2**PRF_ID_W).
//
// Ports:
//   clk    - core clock, rising edge
//   reset  - asynchronous, active-low; clears all entries and read data
//   bus    - iprf_if.slave (write packets in ro0, read requests in rd0,
//            read data out in rd1)
//
// Build macros:
//   IPRF_WR_BYPASS_EN - when defined, a read that hits a same-cycle write
//                       returns the write data (highest matching port wins);
//                       when undefined it returns the pre-write value.
//   IPRF_NUM_WRITES   - default number of write ports (see iprf_if).
//   ASSERT            - enables the same-cycle write-conflict check.

module iprf #(
    parameter int NUM_ENTRIES = 64,
    parameter int NUM_RD      = 2,
    parameter int NUM_WR      = `IPRF_NUM_WRITES,
    parameter int PRF_ID_W    = 8
) (
    input  logic  clk,
    input  logic  reset,
    iprf_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);

    logic [63:0]      regs    [NUM_ENTRIES];
    logic [IDX_W-1:0] wr_idx  [NUM_WR];
    logic [IDX_W-1:0] rd_idx  [NUM_RD];
    logic [63:0]      rd_next [NUM_RD];
    logic [63:0]      rd_q    [NUM_RD];

    // High id bits are intentionally ignored (address wrap).
    logic [NUM_WR+NUM_RD-1:0] unused_id_hi;

    for (genvar w = 0; w < NUM_WR; w++) begin : g_wr_idx
        assign wr_idx[w]       = bus.iprf_wr_pkt_ro0[w].pdst[IDX_W-1:0];
        assign unused_id_hi[w] = ^bus.iprf_wr_pkt_ro0[w].pdst[PRF_ID_W-1:IDX_W];
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_idx
        assign rd_idx[p]              = bus.prf_rdaddrs_rd0[p][IDX_W-1:0];
        assign unused_id_hi[NUM_WR+p] = ^bus.prf_rdaddrs_rd0[p][PRF_ID_W-1:IDX_W];
        assign bus.prf_rddatas_rd1[p] = rd_q[p];
    end

    // Ports are visited in ascending order, so the last non-blocking
    // assignment (highest-numbered port) wins a same-index conflict.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (bus.iprf_wr_en_ro0[w] && (wr_idx[w] != '0)) begin
                    regs[wr_idx[w]] <= bus.iprf_wr_pkt_ro0[w].data;
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_next[p] = (rd_idx[p] == '0) ? 64'h0 : regs[rd_idx[p]];
`ifdef IPRF_WR_BYPASS_EN
            for (int w = 0; w < NUM_WR; w++) begin
                if (bus.iprf_wr_en_ro0[w] && (wr_idx[w] != '0) &&
                    (wr_idx[w] == rd_idx[p])) begin
                    rd_next[p] = bus.iprf_wr_pkt_ro0[w].data;
                end
            end
`endif
        end
    end

    // Read data is enable-gated: it holds while the port is idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NUM_RD; p++) begin
                rd_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_RD; p++) begin
                if (bus.prf_rdens_rd0[p]) begin
                    rd_q[p] <= rd_next[p];
                end
            end
        end
    end

`ifdef ASSERT
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_WR; i++) begin
                for (int j = i + 1; j < NUM_WR; j++) begin
                    assert (!(bus.iprf_wr_en_ro0[i] && bus.iprf_wr_en_ro0[j] &&
                              (wr_idx[i] != '0) && (wr_idx[i] == wr_idx[j])))
                    else $error("iprf: write ports %0d and %0d target entry %0d",
                                i, j, wr_idx[i]);
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_iprf.sv
module tb_iprf;
    localparam int NRD = 2;
    localparam int NWR = 2;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        int          port;
        logic [63:0] val;
        string       tag;
    } exp_t;

    exp_t sbq[$];

    iprf_if #(.NUM_RD(NRD), .NUM_WR(NWR), .PRF_ID_W(8)) bus ();

    iprf #(.NUM_ENTRIES(64), .NUM_RD(NRD), .NUM_WR(NWR), .PRF_ID_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.iprf_wr_en_ro0 = '0;
        bus.prf_rdens_rd0  = '0;
        for (int w = 0; w < NWR; w++) bus.iprf_wr_pkt_ro0[w] = '0;
        for (int p = 0; p < NRD; p++) bus.prf_rdaddrs_rd0[p] = '0;
    endtask

    task automatic wr(input int port, input logic [7:0] addr, input logic [63:0] d);
        bus.iprf_wr_en_ro0[port]  = 1'b1;
        bus.iprf_wr_pkt_ro0[port] = {addr, d};
    endtask

    task automatic rd(input int port, input logic [7:0] addr, input logic [63:0] exp,
                      input string tag);
        exp_t e;
        bus.prf_rdens_rd0[port]   = 1'b1;
        bus.prf_rdaddrs_rd0[port] = addr;
        e.port = port; e.val = exp; e.tag = tag;
        sbq.push_back(e);
    endtask

    task automatic expect_hold(input int port, input logic [63:0] exp, input string tag);
        exp_t e;
        e.port = port; e.val = exp; e.tag = tag;
        sbq.push_back(e);
    endtask

    // Advance one clock, then compare everything queued for this edge.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            check(e.tag, bus.prf_rddatas_rd1[e.port], e.val);
        end
        idle();
    endtask

    initial begin
        logic [63:0] same_exp;
        reset = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("reset_rd0", bus.prf_rddatas_rd1[0], 64'h0);
        check("reset_rd1", bus.prf_rddatas_rd1[1], 64'h0);
        #3 reset = 1'b1;

        rd(0, 8'd5,  64'h0, "post_reset_idx5");
        rd(1, 8'd63, 64'h0, "post_reset_idx63");
        tick();

        wr(0, 8'd7, 64'hDEAD_BEEF_0000_0001);
        tick();
        rd(0, 8'd7, 64'hDEAD_BEEF_0000_0001, "wr_rd_idx7");
        tick();
        for (int i = 0; i < 3; i++) begin
            expect_hold(0, 64'hDEAD_BEEF_0000_0001, "hold_idx7");
            tick();
        end

        wr(0, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        rd(0, 8'd0,  64'h0, "zero_reg");
        rd(1, 8'd64, 64'h0, "zero_reg_wrap");
        tick();

        wr(1, 8'd200, 64'h77);
        tick();
        rd(0, 8'd8, 64'h77, "wrap_wr_idx8");
        tick();

        wr(0, 8'd9, 64'h55);
        tick();
`ifdef IPRF_WR_BYPASS_EN
        same_exp = 64'h1234;
`else
        same_exp = 64'h55;
`endif
        wr(0, 8'd9, 64'h1234);
        rd(1, 8'd9, same_exp, "same_cycle_rw");
        tick();
        rd(1, 8'd9, 64'h1234, "reread_idx9");
        tick();

        wr(0, 8'd3, 64'hA);
        wr(1, 8'd4, 64'hB);
        tick();
        rd(0, 8'd3, 64'hA, "multi_idx3");
        rd(1, 8'd4, 64'hB, "multi_idx4");
        tick();

        wr(0, 8'd10, 64'h1);
        wr(1, 8'd10, 64'h2);
        tick();
        rd(0, 8'd10, 64'h2, "conflict_p0");
        rd(1, 8'd10, 64'h2, "conflict_p1");
        tick();

        rd(0, 8'd4, 64'hB, "pre_reset_idx4");
        rd(1, 8'd3, 64'hA, "pre_reset_idx3");
        tick();
        rd(0, 8'd3, 64'hA, "unused");
        rd(1, 8'd4, 64'hB, "unused");
        sbq.delete();
        #3 reset = 1'b0;
        #1;
        check("midop_reset_rd0", bus.prf_rddatas_rd1[0], 64'h0);
        check("midop_reset_rd1", bus.prf_rddatas_rd1[1], 64'h0);
        idle();
        @(posedge clk);
        #1;
        check("held_reset_rd0", bus.prf_rddatas_rd1[0], 64'h0);
        #3 reset = 1'b1;
        rd(0, 8'd7, 64'h0, "after_reset_idx7");
        rd(1, 8'd4, 64'h0, "after_reset_idx4");
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
